// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: owns the architectural PC, fetches over a req/ready
// handshake, holds the word for decode, then steers the PC from control outputs.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    localparam int unsigned XLEN    = 32,
    localparam int unsigned JTW     = 26
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic [1:0]      pcsrc,
    input  logic            branch,
    input  logic            zero,
    input  logic [XLEN-1:0] branch_imm,
    input  logic [JTW-1:0]  jump_target,
    input  logic [XLEN-1:0] reg_rs,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instr,
    output logic            instr_valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            misalign
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_ERROR = 2'd2
    } state_t;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_J   = 2'b01;
    localparam logic [1:0] PCSRC_JR  = 2'b10;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   instr_q, instr_d;
    logic              valid_q, valid_d;
    logic              mis_q, mis_d;
    logic [XLEN-1:0]   pc_plus4_c;
    logic [XLEN-1:0]   branch_tgt_c;
    logic [XLEN-1:0]   next_pc_c;
    logic              take_branch_c;

    // Next-PC datapath; all adds wrap modulo 2^32.
    always_comb begin
        pc_plus4_c    = pc_q + XLEN'(4);
        branch_tgt_c  = pc_plus4_c + (branch_imm << 2);
        take_branch_c = branch & zero;
        next_pc_c     = pc_plus4_c;
        case (pcsrc)
            PCSRC_SEQ: next_pc_c = take_branch_c ? branch_tgt_c : pc_plus4_c;
            PCSRC_J:   next_pc_c = {pc_plus4_c[31:28], jump_target, 2'b00};
            PCSRC_JR:  next_pc_c = reg_rs;
            default:   next_pc_c = pc_plus4_c;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            mis_q   <= mis_d;
        end
    end

    // Next-state logic; stall outranks a misaligned target so no error is raised mid-stall.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        mis_d   = mis_q;
        case (state_q)
            S_FETCH: begin
                valid_d = 1'b0;
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (!stall) begin
                    valid_d = 1'b0;
                    if (next_pc_c[1:0] == 2'b00) begin
                        pc_d    = next_pc_c;
                        state_d = S_FETCH;
                    end else begin
                        mis_d   = 1'b1;
                        state_d = S_ERROR;
                    end
                end
            end
            S_ERROR: begin
                valid_d = 1'b0;
                mis_d   = 1'b1;
            end
            default: begin
                valid_d = 1'b0;
                state_d = S_FETCH;
            end
        endcase
    end

    // Request is gated by reset so the first fetch appears in the first cycle reset is low.
    assign imem_req    = (state_q == S_FETCH) && !reset;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_plus4_c;
    assign misalign    = mis_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: acts as instruction memory and control unit.
module tb_pc_fetch_unit;

    localparam logic [31:0] RPC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [1:0]  pcsrc;
    logic        branch;
    logic        zero;
    logic [31:0] branch_imm;
    logic [25:0] jump_target;
    logic [31:0] reg_rs;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misalign;

    int ncmp  = 0;
    int nfail = 0;

    pc_fetch_unit #(.RESET_PC(RPC)) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .pcsrc       (pcsrc),
        .branch      (branch),
        .zero        (zero),
        .branch_imm  (branch_imm),
        .jump_target (jump_target),
        .reg_rs      (reg_rs),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .misalign    (misalign)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expects to be in FETCH at exp_addr; memory answers with zero wait.
    task automatic do_fetch(input string tag, input logic [31:0] exp_addr, input logic [31:0] word);
        check({tag, ".req"}, 32'(imem_req), 32'd1);
        check({tag, ".addr"}, imem_addr, exp_addr);
        check({tag, ".vld0"}, 32'(instr_valid), 32'd0);
        imem_ready = 1'b1;
        imem_rdata = word;
        tick();
        imem_ready = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        check({tag, ".instr"}, instr, word);
        check({tag, ".vld1"}, 32'(instr_valid), 32'd1);
        check({tag, ".req0"}, 32'(imem_req), 32'd0);
        check({tag, ".pc"}, pc, exp_addr);
    endtask

    // One unstalled EXEC cycle with the given decode inputs.
    task automatic do_exec(input logic [1:0] ps, input logic br, input logic z,
                           input logic [31:0] imm, input logic [25:0] jt, input logic [31:0] rs);
        stall = 1'b0; pcsrc = ps; branch = br; zero = z;
        branch_imm = imm; jump_target = jt; reg_rs = rs;
        tick();
        pcsrc = 2'b00; branch = 1'b0; zero = 1'b0;
        branch_imm = '0; jump_target = '0; reg_rs = '0;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; pcsrc = 2'b00; branch = 1'b0; zero = 1'b0;
        branch_imm = '0; jump_target = '0; reg_rs = '0;
        imem_ready = 1'b0; imem_rdata = '0;
        tick();
        tick();

        // Reset state
        check("rst.pc", pc, RPC);
        check("rst.instr", instr, 32'h0);
        check("rst.vld", 32'(instr_valid), 32'd0);
        check("rst.req", 32'(imem_req), 32'd0);
        check("rst.mis", 32'(misalign), 32'd0);

        // Sequential, zero-wait memory
        reset = 1'b0;
        #1;
        check("seq.pc4", pc_plus4, 32'h0040_0004);
        do_fetch("seq0", 32'h0040_0000, 32'h1111_0000);
        do_exec(2'b00, 1'b0, 1'b0, '0, '0, '0);
        do_fetch("seq1", 32'h0040_0004, 32'h1111_0004);
        do_exec(2'b00, 1'b0, 1'b0, '0, '0, '0);
        do_fetch("seq2", 32'h0040_0008, 32'h1111_0008);

        // Branch taken / not taken at 0x00400010
        do_exec(2'b10, 1'b0, 1'b0, '0, '0, 32'h0040_0010);
        do_fetch("brA", 32'h0040_0010, 32'h1000_FFFC);
        do_exec(2'b00, 1'b1, 1'b1, 32'hFFFF_FFFC, '0, '0);
        do_fetch("brT", 32'h0040_0004, 32'h2222_0004);
        do_exec(2'b10, 1'b0, 1'b0, '0, '0, 32'h0040_0010);
        do_fetch("brB", 32'h0040_0010, 32'h1000_FFFC);
        do_exec(2'b00, 1'b1, 1'b0, 32'hFFFF_FFFC, '0, '0);
        do_fetch("brN", 32'h0040_0014, 32'h2222_0014);

        // Jump and jump-register
        do_exec(2'b10, 1'b0, 1'b0, '0, '0, 32'h0040_0020);
        do_fetch("jA", 32'h0040_0020, 32'h0810_0003);
        do_exec(2'b01, 1'b0, 1'b0, '0, 26'h010_0003, '0);
        do_fetch("j", 32'h0040_000C, 32'h3333_000C);
        do_exec(2'b10, 1'b0, 1'b0, '0, '0, 32'h0040_0100);
        do_fetch("jr", 32'h0040_0100, 32'h3333_0100);
        do_exec(2'b00, 1'b0, 1'b0, '0, '0, '0);

        // Memory wait: three not-ready cycles, then ready on the fourth
        for (int i = 0; i < 3; i++) begin
            imem_rdata = 32'hBAD0_0000;
            check("wait.req", 32'(imem_req), 32'd1);
            check("wait.addr", imem_addr, 32'h0040_0104);
            tick();
            check("wait.vld", 32'(instr_valid), 32'd0);
        end
        do_fetch("wait", 32'h0040_0104, 32'h4444_0104);

        // Two stall cycles with a misaligned target pending; stall must win
        stall = 1'b1; pcsrc = 2'b10; reg_rs = 32'h0040_0102;
        imem_ready = 1'b1; imem_rdata = 32'hBAD1_0000;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("stall.vld", 32'(instr_valid), 32'd1);
            check("stall.pc", pc, 32'h0040_0104);
            check("stall.instr", instr, 32'h4444_0104);
            check("stall.mis", 32'(misalign), 32'd0);
            check("stall.req", 32'(imem_req), 32'd0);
        end
        imem_ready = 1'b0;
        do_exec(2'b00, 1'b0, 1'b0, '0, '0, '0);
        do_fetch("post", 32'h0040_0108, 32'h5555_0108);

        // Reserved pcsrc is sequential and ignores branch
        do_exec(2'b11, 1'b1, 1'b1, 32'h0000_0010, '0, '0);
        check("rsv.vld", 32'(instr_valid), 32'd0);
        check("rsv.addr", imem_addr, 32'h0040_010C);

        // Reset mid-FETCH with a late ready
        reset = 1'b1; imem_ready = 1'b1; imem_rdata = 32'hBAD2_0000;
        #1;
        check("rf.req", 32'(imem_req), 32'd0);
        tick();
        check("rf.instr", instr, 32'h0);
        check("rf.vld", 32'(instr_valid), 32'd0);
        check("rf.pc", pc, RPC);
        tick();
        check("rf.instr2", instr, 32'h0);
        check("rf.vld2", 32'(instr_valid), 32'd0);
        reset = 1'b0; imem_ready = 1'b0;
        #1;
        do_fetch("rf", 32'h0040_0000, 32'h6666_0000);

        // Wrap-around at the top of the address space
        do_exec(2'b10, 1'b0, 1'b0, '0, '0, 32'hFFFF_FFFC);
        do_fetch("wrap", 32'hFFFF_FFFC, 32'h7777_FFFC);
        check("wrap.pc4", pc_plus4, 32'h0000_0000);
        do_exec(2'b00, 1'b0, 1'b0, '0, '0, '0);
        do_fetch("wrap0", 32'h0000_0000, 32'h7777_0000);

        // Misaligned jr target: sticky ERROR until reset
        do_exec(2'b10, 1'b0, 1'b0, '0, '0, 32'h0040_0102);
        check("err.mis", 32'(misalign), 32'd1);
        check("err.vld", 32'(instr_valid), 32'd0);
        check("err.req", 32'(imem_req), 32'd0);
        check("err.pc", pc, 32'h0000_0000);
        imem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("errh.req", 32'(imem_req), 32'd0);
            check("errh.mis", 32'(misalign), 32'd1);
            check("errh.vld", 32'(instr_valid), 32'd0);
        end
        imem_ready = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("rec.mis", 32'(misalign), 32'd0);
        check("rec.pc", pc, RPC);
        check("rec.req", 32'(imem_req), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Instruction-fetch stage sitting directly upstream of the single-cycle decoder and control unit.
- Holds the architectural PC and fetches each instruction from instruction memory over a ready/req handshake.
- Presents the fetched word to the control unit, then computes the next PC from the control outputs (PCSrc, Branch) and the ALU Zero flag.
- Minimum two cycles per instruction: FETCH, then EXEC.

Parameters:
RESET_PC, 32'h0040_0000, PC value loaded on reset (MIPS text base)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  hold current instruction in EXEC; PC not advanced
pcsrc  input  2  from control unit: 00 sequential/branch, 01 jump, 10 jump-register, 11 reserved
branch  input  1  from control unit: instruction is beq
zero  input  1  ALU zero flag for current instruction
branch_imm  input  32  sign-extended 16-bit immediate of current instruction
jump_target  input  26  instr[25:0] of current instruction
reg_rs  input  32  register-file rs read data (jr/jalr target)
imem_req  output  1  instruction-memory read request
imem_addr  output  32  instruction-memory word address (byte address, [1:0]=00)
imem_ready  input  1  memory returns imem_rdata this cycle
imem_rdata  input  32  instruction word
instr  output  32  latched instruction for decode/control
instr_valid  output  1  instr holds a valid instruction being executed
pc  output  32  PC of the instruction in instr
pc_plus4  output  32  pc + 4, used as the jal/jalr link value
misalign  output  1  sticky error: computed next PC not word-aligned

Behaviour:
- Reset (sync, active-high), applied at the clock edge:
  - pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, misalign=0, state=FETCH.
  - While reset is high, outputs keep these values.
  - The first request is issued in the first cycle with reset low.
- FSM states: FETCH, EXEC, ERROR.
- FETCH:
  - imem_req=1, imem_addr=pc; address held stable until imem_ready.
  - imem_ready=1: instr<=imem_rdata, instr_valid<=1, goto EXEC.
  - imem_ready=0: stay in FETCH, with no bound on wait length.
  - instr_valid=0 throughout.
- EXEC:
  - imem_req=0; instr_valid=1; decode inputs are sampled combinationally this cycle.
  - stall=1: stay in EXEC; pc and instr unchanged.
  - stall=0: compute next_pc (below).
    - next_pc[1:0]==00: pc<=next_pc, instr_valid<=0, goto FETCH.
    - otherwise: misalign<=1, pc unchanged, instr_valid<=0, goto ERROR.
- ERROR: imem_req=0, instr_valid=0, misalign=1; exits only via reset.
- next_pc selection, all arithmetic 32-bit modulo 2^32 (wraps, no overflow flag):
  - pcsrc=00: branch&zero ? pc_plus4 + (branch_imm<<2) : pc_plus4
  - pcsrc=01: {pc_plus4[31:28], jump_target, 2'b00}
  - pcsrc=10: reg_rs
  - pcsrc=11: pc_plus4 (reserved, treated as sequential)
- branch is ignored unless pcsrc=00.
- pc_plus4 = pc + 4 combinationally; pc=32'hFFFF_FFFC gives pc_plus4=0.
- imem_ready outside FETCH is ignored, with no state change.
- Reset mid-FETCH abandons the outstanding request; a late imem_ready during reset is ignored.
- Simultaneous stall=1 and a misaligned next_pc: stall wins, no error raised yet.
- Throughput: zero-wait memory gives one instruction per 2 cycles.

Test Plan:
- Reset then sequential, zero-wait memory, pcsrc=00, branch=0: imem_addr sequence 0x00400000, 0x00400004, 0x00400008; instr_valid pulses every 2nd cycle; pc_plus4=0x00400004 while pc=0x00400000.
- Branch at pc=0x00400010, branch=1, zero=1, branch_imm=0xFFFFFFFC: next fetch 0x00400004. Same instruction with zero=0: next fetch 0x00400014.
- Jump and jump-register:
  - pcsrc=01, jump_target=26'h0100003 at pc=0x00400020: next 0x0040000C.
  - pcsrc=10, reg_rs=0x00400100: next 0x00400100.
  - pcsrc=10, reg_rs=0x00400102: misalign=1, state ERROR, imem_req stays 0 until reset.
- Memory wait plus stall:
  - imem_ready low 3 cycles: imem_req=1 and imem_addr stable for 4 cycles; instr captured on the ready cycle.
  - stall=1 for 2 EXEC cycles: pc/instr unchanged, instr_valid=1 for 3 cycles.
- Reset in FETCH with imem_ready asserted the same cycle: instr=0, instr_valid=0, pc=RESET_PC; next request at 0x00400000.
- Wrap: pc forced via reg_rs=0xFFFFFFFC then sequential: pc_plus4=0; next imem_addr=0x00000000.
